// File: rtl/boot_pkg.sv
// Shared types for the UART boot loader: loader and receiver state encodings.
package boot_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned IDX_W  = 32;

   typedef enum logic [1:0] {
      S_HDR,
      S_LOAD,
      S_RUN,
      S_ERR
   } loader_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer and centre sampling.
module uart_rx
   import boot_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rx,
   output logic              rx_valid,
   output logic [BYTE_W-1:0] rx_byte,
   output logic              rx_ferr
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

   rx_state_t         state;
   logic              sync1;
   logic              sync2;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        bit_idx;
   logic [BYTE_W-1:0] shreg;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         state    <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         rx_valid <= 1'b0;
         rx_byte  <= '0;
         rx_ferr  <= 1'b0;
      end else begin
         sync1    <= rx;
         sync2    <= sync1;
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         case (state)
            RX_IDLE: begin
               cnt <= '0;
               if (!sync2) state <= RX_START;
            end
            // Re-check the start bit at mid-bit to reject short glitches.
            RX_START: begin
               if (cnt == HALF_CNT) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (cnt == FULL_CNT) begin
                  cnt   <= '0;
                  shreg <= {sync2, shreg[BYTE_W-1:1]};
                  if (bit_idx == 3'd7) state <= RX_STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (cnt == FULL_CNT) begin
                  cnt <= '0;
                  if (sync2) begin
                     rx_valid <= 1'b1;
                     rx_byte  <= shreg;
                     state    <= RX_IDLE;
                  end else begin
                     rx_ferr <= 1'b1;
                     state   <= RX_WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            // A broken frame leaves the line low; wait for idle before rearming.
            RX_WAIT_IDLE: begin
               if (sync2) state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a length-prefixed image from UART into core memory, then releases the core.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned MEM_DEPTH    = 16384,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             rx,
   output logic             memEn,
   output logic [WIDTH-1:0] memAddr,
   output logic [WIDTH-1:0] memData,
   output logic             cpu_reset,
   output logic             done,
   output logic             error,
   output logic             frame_err
);

   localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(MEM_DEPTH);

   loader_state_t     state;
   logic              rx_valid;
   logic [BYTE_W-1:0] rx_byte;
   logic              rx_ferr;
   logic [1:0]        hdr_cnt;
   logic [IDX_W-1:0]  len;
   logic [IDX_W-1:0]  index;
   logic [IDX_W-1:0]  hdr_len_c;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_rx (
      .clock   (clock),
      .reset_n (reset_n),
      .rx      (rx),
      .rx_valid(rx_valid),
      .rx_byte (rx_byte),
      .rx_ferr (rx_ferr)
   );

   // Little-endian header: each new byte enters at the top and shifts down.
   assign hdr_len_c = {rx_byte, len[IDX_W-1:BYTE_W]};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_HDR;
         hdr_cnt   <= '0;
         len       <= '0;
         index     <= '0;
         memEn     <= 1'b0;
         memAddr   <= '0;
         memData   <= '0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         memEn <= 1'b0;
         if (rx_ferr) frame_err <= 1'b1;
         case (state)
            S_HDR: begin
               if (rx_valid) begin
                  len     <= hdr_len_c;
                  hdr_cnt <= hdr_cnt + 2'd1;
                  if (hdr_cnt == 2'd3) begin
                     if (hdr_len_c == '0) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                     end else if (hdr_len_c > MAX_LEN) begin
                        state <= S_ERR;
                        error <= 1'b1;
                     end else begin
                        state <= S_LOAD;
                        index <= '0;
                     end
                  end
               end
            end
            // Release happens one edge after the final write via S_RUN.
            S_LOAD: begin
               if (rx_valid) begin
                  memEn   <= 1'b1;
                  memAddr <= WIDTH'(index);
                  memData <= WIDTH'(rx_byte);
                  index   <= index + IDX_W'(1);
                  if (index == len - IDX_W'(1)) state <= S_RUN;
               end
            end
            S_RUN: begin
               cpu_reset <= 1'b0;
               done      <= 1'b1;
            end
            S_ERR: begin
               cpu_reset <= 1'b1;
               error     <= 1'b1;
            end
            default: state <= S_HDR;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: byte-level reference model feeds expected writes to a monitor.
module tb_uart_boot_loader;

   localparam int unsigned CPB   = 8;
   localparam int unsigned W     = 32;
   localparam int unsigned DEPTH = 16384;

   typedef struct {
      int unsigned addr;
      int unsigned data;
   } wr_t;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         rx = 1'b1;
   logic         memEn;
   logic [W-1:0] memAddr;
   logic [W-1:0] memData;
   logic         cpu_reset;
   logic         done;
   logic         error;
   logic         frame_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   wr_t exp_q[$];

   // Reference model: 0=header, 1=loading, 2=running, 3=error.
   int          m_state;
   int          m_cnt;
   int unsigned m_len;
   int unsigned m_idx;
   bit          m_ferr;

   uart_boot_loader #(
      .WIDTH(W),
      .MEM_DEPTH(DEPTH),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .rx       (rx),
      .memEn    (memEn),
      .memAddr  (memAddr),
      .memData  (memData),
      .cpu_reset(cpu_reset),
      .done     (done),
      .error    (error),
      .frame_err(frame_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_cnt   = 0;
      m_len   = 0;
      m_idx   = 0;
      m_ferr  = 0;
   endtask

   task automatic model_byte(input logic [7:0] b, input bit good);
      if (!good) begin
         m_ferr = 1;
         return;
      end
      case (m_state)
         0: begin
            m_len = m_len | (int'(b) << (8 * m_cnt));
            m_cnt++;
            if (m_cnt == 4) begin
               if (m_len == 0) m_state = 2;
               else if (m_len > DEPTH) m_state = 3;
               else begin
                  m_state = 1;
                  m_idx   = 0;
               end
            end
         end
         1: begin
            exp_q.push_back(wr_t'{addr: m_idx, data: int'(b)});
            m_idx++;
            if (m_idx == m_len) m_state = 2;
         end
         default: ;
      endcase
   endtask

   task automatic bit_time(input logic v);
      rx = v;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit good);
      model_byte(b, good);
      @(negedge clock);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(good);
      if (!good) bit_time(1'b1);
      rx = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   task automatic send_len(input int unsigned n);
      for (int i = 0; i < 4; i++) send_frame(8'(n >> (8 * i)), 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_memEn"}, 64'(memEn), 64'd0);
      check({tag, "_memAddr"}, 64'(memAddr), 64'd0);
      check({tag, "_memData"}, 64'(memData), 64'd0);
      check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_error"}, 64'(error), 64'd0);
      check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clock);
      #1 reset_n = 1'b0;
      #1 check_reset_vals(tag);
      exp_q.delete();
      model_reset();
      rx = 1'b1;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   // Wait (bounded) for a terminal state, then compare against the model and prove trailing bytes are ignored.
   task automatic finish_check(input string tag);
      int n = 0;
      while (!(done || error) && n < 400) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_terminal"}, 64'(done | error), 64'd1);
      check({tag, "_done"}, 64'(done), 64'(m_state == 2));
      check({tag, "_error"}, 64'(error), 64'(m_state == 3));
      check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(m_state != 2));
      check({tag, "_frame_err"}, 64'(frame_err), 64'(m_ferr));
      check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
      send_frame(8'($urandom), 1'b1);
      send_frame(8'($urandom), 1'b1);
      repeat (4) @(negedge clock);
      check({tag, "_post_done"}, 64'(done), 64'(m_state == 2));
      check({tag, "_post_error"}, 64'(error), 64'(m_state == 3));
   endtask

   // Monitor: pops expected writes and checks pulse width and release timing.
   logic prev_en;
   logic prev_done;
   int   last_we;
   always @(negedge clock) begin
      if (!reset_n) begin
         prev_en   = 1'b0;
         prev_done = 1'b0;
         last_we   = -1;
      end else begin
         if (memEn) begin
            check("en_single_cycle", 64'(prev_en), 64'd0);
            check("en_before_run", 64'(done), 64'd0);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr=%0h data=%0h expected no write", memAddr, memData);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", 64'(memAddr), 64'(e.addr));
               check("wr_data", 64'(memData), 64'(e.data));
            end
            last_we = cyc;
         end
         if (done && !prev_done && last_we >= 0)
            check("release_latency", 64'(cyc - last_we), 64'd1);
         prev_en   = memEn;
         prev_done = done;
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clock);
      check_reset_vals("por");
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      send_len(4);
      send_frame(8'h13, 1'b1);
      for (int i = 0; i < 3; i++) send_frame(8'h00, 1'b1);
      finish_check("normal");

      do_reset("rst_a");
      send_len(0);
      finish_check("empty");

      do_reset("rst_b");
      send_len(32'd16385);
      finish_check("oversize");

      do_reset("rst_c");
      send_len(32'hFFFF_FFFF);
      finish_check("oversize_max");

      do_reset("rst_d");
      send_len(2);
      send_frame(8'hAA, 1'b0);
      send_frame(8'h55, 1'b1);
      send_frame(8'h66, 1'b1);
      finish_check("framing");

      do_reset("rst_e");
      @(negedge clock);
      rx = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      repeat (40) @(negedge clock);
      check("glitch_done", 64'(done), 64'd0);
      check("glitch_cpu_reset", 64'(cpu_reset), 64'd1);
      check("glitch_frame_err", 64'(frame_err), 64'd0);
      send_len(1);
      send_frame(8'h5A, 1'b1);
      finish_check("glitch");

      do_reset("rst_f");
      send_len(DEPTH);
      send_frame(8'hC3, 1'b1);
      send_frame(8'h3C, 1'b1);
      repeat (10) @(negedge clock);
      check("maxlen_error", 64'(error), 64'd0);
      check("maxlen_done", 64'(done), 64'd0);
      check("maxlen_pending", 64'(exp_q.size()), 64'd0);

      do_reset("rst_g");
      send_len(8);
      for (int i = 0; i < 3; i++) send_frame(8'(8'h20 + i), 1'b1);
      check("midload_pending", 64'(exp_q.size()), 64'd0);
      do_reset("midload");
      send_len(1);
      send_frame(8'h7F, 1'b1);
      finish_check("reload");

      for (int t = 0; t < 6; t++) begin
         int unsigned n;
         do_reset("rst_rand");
         n = $urandom_range(1, 10);
         send_len(n);
         for (int i = 0; i < int'(n); i++) begin
            if ($urandom_range(0, 4) == 0) send_frame(8'($urandom), 1'b0);
            send_frame(8'($urandom), 1'b1);
         end
         finish_check("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
